// File: rtl/cog_pkg.sv
// Shared types and widths for the CoG frame controller slice.
package cog_pkg;

   localparam int DIM_W = 11;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } ctrl_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cog_geom_counter.sv
// Pixel/line position tracker; flags line ends, frame end and tlast/width disagreement.
module cog_geom_counter
   import cog_pkg::*;
(
   input  logic             i_sys_clk,
   input  logic             i_sys_reset,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   input  logic             beat,
   input  logic             tlast,
   input  logic             tuser,
   input  logic             clear,
   output logic             line_end,
   output logic             frame_end,
   output logic             geom_err
);

   logic [DIM_W-1:0] x_reg;
   logic [DIM_W-1:0] y_reg;
   logic             counting;
   logic             at_last_px;

   // A tuser beat is pixel 0 of a (re)started frame and is never judged as a line end.
   assign counting   = beat & ~tuser;
   assign at_last_px = (x_reg == width - DIM_W'(1));
   assign line_end   = counting & (tlast | at_last_px);
   assign frame_end  = line_end & (y_reg == height - DIM_W'(1));
   assign geom_err   = counting & (tlast ^ at_last_px);

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset || clear) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (beat && tuser) begin
         x_reg <= DIM_W'(1);
         y_reg <= '0;
      end else if (line_end) begin
         x_reg <= '0;
         y_reg <= y_reg + DIM_W'(1);
      end else if (counting) begin
         x_reg <= x_reg + DIM_W'(1);
      end
   end

endmodule

// File: rtl/cog_frame_ctrl.sv
// Frame-level gate in front of the CoG receiver: arms, aligns to tuser, forwards whole frames.
// Optional DRAIN watchdog enabled by defining COG_CTRL_TIMEOUT_EN.
module cog_frame_ctrl
   import cog_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_reset,
   input  logic [DIM_W-1:0]        cfg_width,
   input  logic [DIM_W-1:0]        cfg_height,
   input  logic                    cfg_continuous,
   input  logic                    cfg_start,
   input  logic                    cfg_stop,
   input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tuser,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [3*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [DIM_W-1:0]        o_width,
   output logic [DIM_W-1:0]        o_height,
   input  logic                    i_end_of_frame,
   input  logic                    i_end_of_fig,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic [CNT_W-1:0]        o_frame_cnt,
   output logic [CNT_W-1:0]        o_fig_cnt,
   output logic                    o_err_geom,
   output logic                    o_err_timeout
);

   ctrl_state_t      state_reg;
   logic [DIM_W-1:0] width_reg;
   logic [DIM_W-1:0] height_reg;
   logic [CNT_W-1:0] fig_reg;
   logic [CNT_W-1:0] fig_next;
   logic [CNT_W-1:0] frame_cnt_reg;
   logic [CNT_W-1:0] fig_cnt_reg;
   logic             frame_done_reg;
   logic             err_geom_reg;
   logic             stop_pending_reg;

   logic             accepted;
   logic             frame_start;
   logic             run_beat;
   logic             restart;
   logic             cfg_ok;
   logic             start_ok;
   logic             line_end;
   logic             frame_end;
   logic             geom_err;
   logic             timeout_hit;

   assign accepted    = s_axis_tvalid & s_axis_tready;
   assign frame_start = accepted & s_axis_tuser & (state_reg == ARMED);
   assign run_beat    = accepted & (state_reg == RUN);
   assign restart     = run_beat & s_axis_tuser;
   assign cfg_ok      = (cfg_width >= DIM_W'(3)) & (cfg_height >= DIM_W'(1));
   assign start_ok    = (state_reg == IDLE) & cfg_start & ~cfg_stop & cfg_ok;

   // Zero-latency pass-through; in ARMED only the frame-start beat is let through.
   assign s_axis_tready = (state_reg == ARMED) | ((state_reg == RUN) & m_axis_tready);
   assign m_axis_tvalid = s_axis_tvalid &
                          ((state_reg == RUN) | ((state_reg == ARMED) & s_axis_tuser));
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;

   always_comb begin
      fig_next = fig_reg;
      if (i_end_of_fig && (state_reg != IDLE)) begin
         fig_next = sat_inc(fig_reg);
      end
   end

   cog_geom_counter u_geom (
      .i_sys_clk   (i_sys_clk),
      .i_sys_reset (i_sys_reset),
      .width       (width_reg),
      .height      (height_reg),
      .beat        (frame_start | run_beat),
      .tlast       (s_axis_tlast),
      .tuser       (s_axis_tuser),
      .clear       (state_reg == IDLE),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .geom_err    (geom_err)
   );

`ifdef COG_CTRL_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] drain_tmr_reg;
   logic             err_timeout_reg;

   assign timeout_hit = (state_reg == DRAIN) & ~i_end_of_frame &
                        (drain_tmr_reg == TMR_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset) begin
         drain_tmr_reg   <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         drain_tmr_reg <= (state_reg == DRAIN) ? drain_tmr_reg + TMR_W'(1) : '0;
         if (start_ok) begin
            err_timeout_reg <= 1'b0;
         end else if (timeout_hit) begin
            err_timeout_reg <= 1'b1;
         end
      end
   end

   assign o_err_timeout = err_timeout_reg;
`else
   assign timeout_hit   = 1'b0;
   // Watchdog absent: flag is constant low for any legal TIMEOUT_CYCLES.
   assign o_err_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset) begin
         state_reg        <= IDLE;
         width_reg        <= '0;
         height_reg       <= '0;
         fig_reg          <= '0;
         frame_cnt_reg    <= '0;
         fig_cnt_reg      <= '0;
         frame_done_reg   <= 1'b0;
         err_geom_reg     <= 1'b0;
         stop_pending_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         fig_reg        <= fig_next;
         case (state_reg)
            IDLE: begin
               stop_pending_reg <= 1'b0;
               if (start_ok) begin
                  state_reg    <= ARMED;
                  err_geom_reg <= 1'b0;
               end
            end
            ARMED: begin
               // The frame-start beat is already on the receiver bus, so a
               // coincident stop lets that frame finish instead of cutting it.
               if (frame_start) begin
                  width_reg        <= cfg_width;
                  height_reg       <= cfg_height;
                  fig_reg          <= '0;
                  state_reg        <= RUN;
                  stop_pending_reg <= cfg_stop;
               end else if (cfg_stop) begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               if (cfg_stop) begin
                  stop_pending_reg <= 1'b1;
               end
               if (restart) begin
                  err_geom_reg <= 1'b1;
                  fig_reg      <= '0;
               end else if (geom_err) begin
                  err_geom_reg <= 1'b1;
               end
               if (frame_end) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (cfg_stop) begin
                  stop_pending_reg <= 1'b1;
               end
               if (i_end_of_frame) begin
                  frame_done_reg <= 1'b1;
                  frame_cnt_reg  <= frame_cnt_reg + CNT_W'(1);
                  fig_cnt_reg    <= fig_next;
                  if (cfg_continuous && !stop_pending_reg && !cfg_stop) begin
                     state_reg <= ARMED;
                  end else begin
                     state_reg        <= IDLE;
                     stop_pending_reg <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  state_reg        <= IDLE;
                  stop_pending_reg <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign o_busy       = (state_reg != IDLE);
   assign o_width      = width_reg;
   assign o_height     = height_reg;
   assign o_frame_done = frame_done_reg;
   assign o_frame_cnt  = frame_cnt_reg;
   assign o_fig_cnt    = fig_cnt_reg;
   assign o_err_geom   = err_geom_reg;

endmodule

// File: doc/cog_frame_ctrl.md
Name: cog_frame_ctrl

Overview:
Frame-level controller placed in front of the CoG receiver FSM on the AXIS video path.
- Arms on a software start pulse, discards beats until start-of-frame (tuser), then forwards whole frames only.
- Checks frame geometry against the configured width/height and presents the active WIDTH/HEIGHT to the receiver, latched at frame start.
- After the last pixel it waits for the receiver's end-of-frame, then reports completion, frame count and figure count (single-shot or continuous mode).

Parameters:
DATA_WIDTH, 8, bits per channel; AXIS tdata is 3*DATA_WIDTH
TIMEOUT_CYCLES, 4096, DRAIN watchdog limit (used only with COG_CTRL_TIMEOUT_EN)

Ports:
i_sys_clk  in  1  system clock
i_sys_reset  in  1  synchronous, active-high reset
cfg_width  in  11  frame width in pixels
cfg_height  in  11  frame height in lines
cfg_continuous  in  1  1 = re-arm after each frame
cfg_start  in  1  single-cycle start pulse
cfg_stop  in  1  single-cycle stop pulse
s_axis_tdata/tvalid/tuser/tlast  in  3*DATA_WIDTH/1/1/1  upstream video
s_axis_tready  out  1  upstream ready
m_axis_tdata/tvalid/tuser/tlast  out  3*DATA_WIDTH/1/1/1  to receiver
m_axis_tready  in  1  receiver ready
o_width, o_height  out  11  active geometry to receiver
i_end_of_frame  in  1  receiver end-of-frame pulse
i_end_of_fig  in  1  receiver end-of-figure pulse
o_busy  out  1  state != IDLE
o_frame_done  out  1  one-cycle pulse per completed frame
o_frame_cnt  out  16  completed frames, wraps at 0xFFFF
o_fig_cnt  out  16  figures in last completed frame
o_err_geom  out  1  sticky geometry error
o_err_timeout  out  1  sticky drain timeout (tied 0 without the feature)

Behaviour:
- Reset: state=IDLE; all outputs and counters 0; s_axis_tready=0; m_axis_tvalid=0.
- Reset mid-frame aborts immediately; no o_frame_done is produced.
- Accepted beat: s_axis_tvalid & s_axis_tready.
- States: IDLE, ARMED, RUN, DRAIN.
- IDLE:
  - s_axis_tready=0.
  - cfg_start with cfg_width>=3 and cfg_height>=1 -> ARMED; sticky errors clear in the same cycle.
  - cfg_start with bad config is ignored.
  - cfg_start and cfg_stop in the same cycle: stop wins, stay IDLE.
- ARMED:
  - s_axis_tready=1; beats are dropped (m_axis_tvalid=0) until an accepted beat has tuser=1.
  - On that tuser beat: latch cfg_width/cfg_height into o_width/o_height; forward the beat combinationally; x=1, y=0; fig counter=0; -> RUN.
  - cfg_stop -> IDLE.
- RUN, pass-through:
  - m_axis_t* = s_axis_t*.
  - s_axis_tready = m_axis_tready.
  - Zero added latency.
- x/y counters (RUN):
  - Line ends on the first of: accepted tlast, or x==o_width-1 accepted.
  - If tlast and x==o_width-1 do not coincide -> o_err_geom=1.
  - At line end: x=0, y+=1.
  - Line end at y==o_height-1 -> DRAIN.
- tuser on an accepted beat in RUN, other than the first beat:
  - o_err_geom=1; beat forwarded; x=1, y=0; fig counter=0.
  - Aborted frame is not counted.
- i_end_of_fig in ARMED/RUN/DRAIN: fig counter +1, saturating at 0xFFFF.
- DRAIN:
  - s_axis_tready=0, m_axis_tvalid=0.
  - On i_end_of_frame: o_frame_done=1 for one cycle; o_frame_cnt+=1; o_fig_cnt <= fig counter, including an i_end_of_fig arriving in the same cycle.
  - Then: -> ARMED if cfg_continuous and no stop pending, else -> IDLE.
- cfg_stop in RUN/DRAIN sets stop_pending; the current frame completes, then -> IDLE. stop_pending clears on entering IDLE.
- cfg_start outside IDLE is ignored.
- o_width/o_height are stable from the frame-start beat until the next frame-start beat.

Optional Feature:
COG_CTRL_TIMEOUT_EN
- Defined:
  - Cycle counter runs in DRAIN.
  - Reaching TIMEOUT_CYCLES without i_end_of_frame: o_err_timeout=1, -> IDLE.
  - No o_frame_done; o_frame_cnt unchanged.
- Undefined: DRAIN waits indefinitely; o_err_timeout tied 0.

Decomposition:
- Package cog_pkg:
  - state enum ctrl_state_t {IDLE, ARMED, RUN, DRAIN}
  - DIM_W=11
  - CNT_W=16
- Sub-module cog_geom_counter:
  - Holds the x/y counters.
  - Inputs: beat, tlast, tuser, clear.
  - Outputs: line_end, frame_end, geom_err.

Test Plan:
1. Width 8, height 4; start; 2 junk beats then a clean 32-beat frame with tuser on beat 0 and tlast every 8th -> junk dropped, 32 beats forwarded, DRAIN; i_end_of_frame -> o_frame_done pulse, o_frame_cnt=1, back to IDLE.
2. Continuous mode, 3 frames, 2 i_end_of_fig pulses per frame -> o_frame_cnt=3, o_fig_cnt=2; cfg_stop during frame 3 -> frame 3 completes, then IDLE.
3. Width 8, tlast arrives at x=5 on line 1 -> o_err_geom=1, y advances to 2, frame still completes after 4 line ends.
4. tuser on beat 13 of a running frame -> o_err_geom=1, counters restart, frame_cnt increments only once the new frame completes.
5. m_axis_tready held low 5 cycles mid-line -> s_axis_tready low for the same 5 cycles, no beat lost or duplicated; cfg_start with cfg_width=2 in IDLE -> stays IDLE.
6. (COG_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16) No i_end_of_frame in DRAIN -> o_err_timeout=1 after 16 cycles, IDLE, o_frame_cnt unchanged.
